// File: rtl/cdb_arbiter_pkg.sv
// Shared widths, requester ids and small index helpers for the CDB arbiter.
// Requester ids match the slice order of the flattened request buses.
package cdb_arbiter_pkg;

  localparam int CDB_N_REQ     = 3;
  localparam int CDB_DATA_W    = 32;
  localparam int CDB_ADDR_W    = 32;
  localparam int CDB_ROB_IDX_W = 4;

  typedef enum logic [1:0] {
    CDB_SRC_ALU0 = 2'd0,
    CDB_SRC_ALU1 = 2'd1,
    CDB_SRC_LSB  = 2'd2
  } cdb_src_e;

  // A single requester still needs a 1-bit source id.
  function automatic int src_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Plain modulo-n increment; n need not be a power of two.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr wins.
// Produces a one-hot grant, an any-grant flag and the winning index.
module cdb_arbiter_rr_pick #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic             any,
  output logic [IDX_W-1:0] win
);

  int idx;

  always_comb begin
    grant = '0;
    any   = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        win        = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding slot per completing unit, round-robin
// selection of one slot per cycle, registered broadcast to ROB/RS/LSB.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int  N_REQ     = CDB_N_REQ,
  parameter int  DATA_W    = CDB_DATA_W,
  parameter int  ADDR_W    = CDB_ADDR_W,
  parameter int  ROB_IDX_W = CDB_ROB_IDX_W,
  localparam int SRC_W     = src_width(N_REQ)
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      clr_in,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*DATA_W-1:0]   req_result,
  input  logic [N_REQ*ROB_IDX_W-1:0] req_rob_index,
  input  logic [N_REQ-1:0]          req_branch,
  input  logic [N_REQ*ADDR_W-1:0]   req_newPC,
  output logic                      cdb_ready,
  output logic [DATA_W-1:0]         cdb_result,
  output logic [ROB_IDX_W-1:0]      cdb_rob_index,
  output logic                      cdb_branch,
  output logic [ADDR_W-1:0]         cdb_newPC,
  output logic [SRC_W-1:0]          cdb_src
);

  logic                 slot_valid_reg  [N_REQ];
  logic [DATA_W-1:0]    slot_result_reg [N_REQ];
  logic [ROB_IDX_W-1:0] slot_rob_reg    [N_REQ];
  logic                 slot_branch_reg [N_REQ];
  logic [ADDR_W-1:0]    slot_pc_reg     [N_REQ];
  logic [SRC_W-1:0]     rr_ptr_reg;

  logic [N_REQ-1:0] slot_occupied;
  logic [N_REQ-1:0] grant;
  logic             grant_any;
  logic [SRC_W-1:0] win;
  logic             accept_en;

  // Reset also blocks acceptance so nothing handed over during reset is lost.
  assign accept_en = rdy_in && !clr_in && !rst_in;

  cdb_arbiter_rr_pick #(
    .N     (N_REQ),
    .IDX_W (SRC_W)
  ) u_pick (
    .req   (slot_occupied),
    .ptr   (rr_ptr_reg),
    .grant (grant),
    .any   (grant_any),
    .win   (win)
  );

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slot
      assign slot_occupied[gi] = slot_valid_reg[gi];
      // A slot being drained this cycle can take a new entry in the same cycle.
      assign req_ready[gi] = accept_en && (!slot_valid_reg[gi] || grant[gi]);

      always_ff @(posedge clk_in) begin
        if (rst_in || clr_in) begin
          slot_valid_reg[gi] <= 1'b0;
        end else if (rdy_in) begin
          if (req_valid[gi] && req_ready[gi]) begin
            slot_valid_reg[gi]  <= 1'b1;
            slot_result_reg[gi] <= req_result[gi*DATA_W +: DATA_W];
            slot_rob_reg[gi]    <= req_rob_index[gi*ROB_IDX_W +: ROB_IDX_W];
            slot_branch_reg[gi] <= req_branch[gi];
            slot_pc_reg[gi]     <= req_newPC[gi*ADDR_W +: ADDR_W];
          end else if (grant[gi]) begin
            slot_valid_reg[gi] <= 1'b0;
          end
        end
      end
    end
  endgenerate

  // Flush drops the pending broadcast but leaves the data buses as they were.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cdb_ready     <= 1'b0;
      cdb_result    <= '0;
      cdb_rob_index <= '0;
      cdb_branch    <= 1'b0;
      cdb_newPC     <= '0;
      cdb_src       <= '0;
      rr_ptr_reg    <= '0;
    end else if (clr_in) begin
      cdb_ready  <= 1'b0;
      rr_ptr_reg <= '0;
    end else if (rdy_in) begin
      if (grant_any) begin
        cdb_ready     <= 1'b1;
        cdb_result    <= slot_result_reg[win];
        cdb_rob_index <= slot_rob_reg[win];
        cdb_branch    <= slot_branch_reg[win];
        cdb_newPC     <= slot_pc_reg[win];
        cdb_src       <= win;
        rr_ptr_reg    <= SRC_W'(wrap_inc(int'(win), N_REQ));
      end else begin
        cdb_ready <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: per-requester scoreboards filled on
// accepted transfers and drained on each live broadcast, plus directed checks.
module tb_cdb_arbiter;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int RW = 4;
  localparam int EW = DW + RW + 1 + AW;

  logic            clk_in = 1'b0;
  logic            rst_in, rdy_in, clr_in;
  logic [N-1:0]    req_valid, req_ready, req_branch;
  logic [N*DW-1:0] req_result;
  logic [N*RW-1:0] req_rob_index;
  logic [N*AW-1:0] req_newPC;
  logic            cdb_ready, cdb_branch;
  logic [DW-1:0]   cdb_result;
  logic [RW-1:0]   cdb_rob_index;
  logic [AW-1:0]   cdb_newPC;
  logic [1:0]      cdb_src;

  int tests_run    = 0;
  int tests_failed = 0;
  int seq [N];

  logic [EW-1:0] sb0 [$];
  logic [EW-1:0] sb1 [$];
  logic [EW-1:0] sb2 [$];
  logic          live_edge = 1'b0;
  logic [N-1:0]  xfer_q = '0;
  logic [EW-1:0] exp0;

  cdb_arbiter dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .clr_in        (clr_in),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_result    (req_result),
    .req_rob_index (req_rob_index),
    .req_branch    (req_branch),
    .req_newPC     (req_newPC),
    .cdb_ready     (cdb_ready),
    .cdb_result    (cdb_result),
    .cdb_rob_index (cdb_rob_index),
    .cdb_branch    (cdb_branch),
    .cdb_newPC     (cdb_newPC),
    .cdb_src       (cdb_src)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_val(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [EW-1:0] mk_entry(input int i, input int s);
    logic [DW-1:0] r;
    logic [AW-1:0] pc;
    r  = (32'(i) << 28) | 32'(s * 17 + 3);
    pc = 32'h0000_1000 + 32'(s * 4) + (32'(i) << 16);
    return {r, 4'(s), 1'(s & 1), pc};
  endfunction

  function automatic logic [EW-1:0] in_entry(input int i);
    return {req_result[i*DW +: DW], req_rob_index[i*RW +: RW], req_branch[i], req_newPC[i*AW +: AW]};
  endfunction

  task automatic drive_data(input int i);
    logic [EW-1:0] e;
    e = mk_entry(i, seq[i]);
    req_result[i*DW +: DW]    = e[EW-1 -: DW];
    req_rob_index[i*RW +: RW] = e[AW+RW:AW+1];
    req_branch[i]             = e[AW];
    req_newPC[i*AW +: AW]     = e[AW-1:0];
  endtask

  function automatic int sb_size(input int i);
    case (i)
      0:       return sb0.size();
      1:       return sb1.size();
      default: return sb2.size();
    endcase
  endfunction

  function automatic logic [EW-1:0] sb_pop(input int i);
    case (i)
      0:       return sb0.pop_front();
      1:       return sb1.pop_front();
      default: return sb2.pop_front();
    endcase
  endfunction

  // Input side: record every accepted transfer as an expected broadcast.
  always @(posedge clk_in) begin
    live_edge = rdy_in && !rst_in && !clr_in;
    xfer_q    = '0;
    if (rst_in || clr_in) begin
      sb0.delete();
      sb1.delete();
      sb2.delete();
    end else begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          xfer_q[i] = 1'b1;
          case (i)
            0:       sb0.push_back(in_entry(i));
            1:       sb1.push_back(in_entry(i));
            default: sb2.push_back(in_entry(i));
          endcase
        end
      end
    end
  end

  // Output side: every live broadcast must match the oldest entry of its source.
  always @(negedge clk_in) begin
    int s;
    if (live_edge && cdb_ready === 1'b1) begin
      s = int'(cdb_src);
      check_val("cdb_src_range", 96'(s < N), 96'd1);
      if (s < N) begin
        check_val("sb_nonempty", 96'(sb_size(s) != 0), 96'd1);
        if (sb_size(s) != 0)
          check_val($sformatf("bcast_src%0d", s),
                    {cdb_result, cdb_rob_index, cdb_branch, cdb_newPC}, sb_pop(s));
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
    for (int i = 0; i < N; i++) begin
      if (xfer_q[i]) begin
        seq[i]++;
        drive_data(i);
      end
    end
  endtask

  task automatic do_reset();
    rst_in    = 1'b1;
    req_valid = '0;
    tick();
    rst_in = 1'b0;
  endtask

  initial begin
    rst_in    = 1'b1;
    rdy_in    = 1'b1;
    clr_in    = 1'b0;
    req_valid = 3'b111;
    for (int i = 0; i < N; i++) begin
      seq[i] = 10 * (i + 1);
      drive_data(i);
    end

    // Reset with all requesters offering
    tick();
    tick();
    @(negedge clk_in);
    check_val("rst_req_ready", 96'(req_ready), 96'd0);
    check_val("rst_cdb_ready", 96'(cdb_ready), 96'd0);
    check_val("rst_cdb_src", 96'(cdb_src), 96'd0);
    check_val("rst_cdb_result", 96'(cdb_result), 96'd0);
    check_val("rst_cdb_rob", 96'(cdb_rob_index), 96'd0);
    req_valid = '0;
    rst_in    = 1'b0;
    #1;
    check_val("rst_release_ready", 96'(req_ready), 96'b111);

    // Single result from ALU0
    drive_data(0);
    req_result[0 +: DW]    = 32'h1234;
    req_rob_index[0 +: RW] = 4'd5;
    req_valid = 3'b001;
    tick();
    req_valid = '0;
    @(negedge clk_in);
    check_val("single_latency", 96'(cdb_ready), 96'd0);
    tick();
    @(negedge clk_in);
    check_val("single_ready", 96'(cdb_ready), 96'd1);
    check_val("single_result", 96'(cdb_result), 96'h1234);
    check_val("single_rob", 96'(cdb_rob_index), 96'd5);
    check_val("single_src", 96'(cdb_src), 96'd0);
    tick();
    @(negedge clk_in);
    check_val("single_pulse", 96'(cdb_ready), 96'd0);

    // Full contention
    do_reset();
    req_valid = 3'b111;
    tick();
    for (int k = 0; k < 9; k++) begin
      tick();
      @(negedge clk_in);
      check_val($sformatf("cont_ready_%0d", k), 96'(cdb_ready), 96'd1);
      check_val($sformatf("cont_src_%0d", k), 96'(cdb_src), 96'(k % 3));
      check_val($sformatf("cont_req_ready_%0d", k), 96'(req_ready), 96'(3'b001 << ((k + 1) % 3)));
    end
    req_valid = '0;
    repeat (4) tick();

    // LSB streams alone without bubbles
    do_reset();
    seq[2] = 1;
    drive_data(2);
    req_valid = 3'b100;
    tick();
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (seq[2] >= 4) req_valid[2] = 1'b0;
      @(negedge clk_in);
      check_val($sformatf("refill_ready_%0d", k), 96'(cdb_ready), 96'd1);
      check_val($sformatf("refill_rob_%0d", k), 96'(cdb_rob_index), 96'(k));
      check_val($sformatf("refill_src_%0d", k), 96'(cdb_src), 96'd2);
    end
    tick();
    @(negedge clk_in);
    check_val("refill_end", 96'(cdb_ready), 96'd0);

    // Flush with slots 0 and 1 occupied, pointer moved off zero beforehand
    do_reset();
    req_valid = 3'b001;
    tick();
    req_valid = '0;
    tick();
    req_valid = 3'b011;
    tick();
    req_valid = '0;
    clr_in    = 1'b1;
    @(negedge clk_in);
    check_val("clr_req_ready", 96'(req_ready), 96'd0);
    tick();
    clr_in = 1'b0;
    @(negedge clk_in);
    check_val("flush_no_bcast", 96'(cdb_ready), 96'd0);
    check_val("flush_slots_free", 96'(req_ready), 96'b111);
    tick();
    @(negedge clk_in);
    check_val("flush_still_idle", 96'(cdb_ready), 96'd0);
    req_valid = 3'b111;
    tick();
    req_valid = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk_in);
      check_val($sformatf("post_flush_ready_%0d", k), 96'(cdb_ready), 96'd1);
      check_val($sformatf("post_flush_src_%0d", k), 96'(cdb_src), 96'(k));
    end

    // Freeze with slot 1 occupied and slot 0 on the bus
    do_reset();
    exp0      = in_entry(0);
    req_valid = 3'b001;
    tick();
    req_valid = 3'b010;
    tick();
    req_valid = '0;
    rdy_in    = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_in);
      check_val($sformatf("freeze_req_ready_%0d", k), 96'(req_ready), 96'd0);
      check_val($sformatf("freeze_cdb_ready_%0d", k), 96'(cdb_ready), 96'd1);
      check_val($sformatf("freeze_cdb_src_%0d", k), 96'(cdb_src), 96'd0);
      check_val($sformatf("freeze_cdb_data_%0d", k),
                {cdb_result, cdb_rob_index, cdb_branch, cdb_newPC}, exp0);
      tick();
    end
    rdy_in = 1'b1;
    tick();
    @(negedge clk_in);
    check_val("thaw_ready", 96'(cdb_ready), 96'd1);
    check_val("thaw_src", 96'(cdb_src), 96'd1);

    repeat (3) tick();
    check_val("drain_q0", 96'(sb_size(0)), 96'd0);
    check_val("drain_q1", 96'(sb_size(1)), 96'd0);
    check_val("drain_q2", 96'(sb_size(2)), 96'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
